// File: rtl/chirp_pkg.sv
// Shared types and default widths for the chirp phase generator.
package chirp_pkg;
    localparam int WACC_DEF   = 48;
    localparam int WPHASE_DEF = 16;
    localparam int WDIV_DEF   = 8;

    typedef enum logic [1:0] {
        MODE_TONE   = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_SINGLE = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_LAST,
        ST_DONE
    } state_t;
endpackage

// File: rtl/chirp_phase_gen_if.sv
// Control/config and sample-output bundle between a stimulus controller and the generator.
interface chirp_phase_gen_if #(
    parameter int WACC   = 48,
    parameter int WPHASE = 16,
    parameter int WDIV   = 8
);
    logic              enable;
    logic [1:0]        mode;
    logic [WDIV-1:0]   div;
    logic [WACC-1:0]   f_start;
    logic [WACC-1:0]   f_stop;
    logic [WACC-1:0]   rate;
    logic              phase_valid;
    logic [WPHASE-1:0] phase_out;
    logic [WACC-1:0]   freq_out;
    logic              sweep_wrap;
    logic              busy;
    logic              done;

    modport master (
        output enable, mode, div, f_start, f_stop, rate,
        input  phase_valid, phase_out, freq_out, sweep_wrap, busy, done
    );

    modport slave (
        input  enable, mode, div, f_start, f_stop, rate,
        output phase_valid, phase_out, freq_out, sweep_wrap, busy, done
    );
endinterface

// File: rtl/chirp_phase_gen_strobe_div.sv
// Programmable strobe divider: fires when the count is zero, then reloads div.
module strobe_div #(
    parameter int WDIV = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            run,
    input  logic [WDIV-1:0] div,
    output logic            strobe
);
    logic [WDIV-1:0] count;

    assign strobe = run && (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == '0) ? div : count - WDIV'(1);
        end
    end
endmodule

// File: rtl/chirp_phase_gen.sv
// Swept-frequency phase accumulator feeding a sine ROM; tone, wrap, bounce or single sweep.
module chirp_phase_gen
    import chirp_pkg::*;
#(
    parameter int WACC   = WACC_DEF,
    parameter int WPHASE = WPHASE_DEF,
    parameter int WDIV   = WDIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    chirp_phase_gen_if.slave  bus
);
    state_t            state, state_nx;
    mode_t             mode_q;
    logic [WDIV-1:0]   div_q;
    logic [WACC-1:0]   f_start_q, f_stop_q, rate_q;
    logic [WACC-1:0]   phase, freq, freq_nx;
    logic              wrap_pend, wrap_nx;
    logic [WACC:0]     up_sum, dn_diff;
    logic              start, run, strobe;
    logic              valid_q, wrap_q;
    logic [WPHASE-1:0] phase_q;
    logic [WACC-1:0]   freq_q;

    assign start = (state == ST_IDLE) && bus.enable;
    assign run   = bus.enable && (state inside {ST_UP, ST_DOWN, ST_LAST});

    strobe_div #(.WDIV(WDIV)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start),
        .run    (run),
        .div    (div_q),
        .strobe (strobe)
    );

    // One extra bit keeps overflow visible on the way up and the sign on the way down.
    assign up_sum  = {1'b0, freq} + {1'b0, rate_q};
    assign dn_diff = {1'b0, freq} - {1'b0, rate_q};

    always_comb begin
        state_nx = state;
        freq_nx  = freq;
        wrap_nx  = 1'b0;
        case (state)
            ST_IDLE: if (bus.enable) state_nx = ST_UP;
            ST_UP: begin
                if (!bus.enable) begin
                    state_nx = ST_IDLE;
                end else if (strobe && mode_q != MODE_TONE) begin
                    if (up_sum <= {1'b0, f_stop_q}) begin
                        freq_nx = up_sum[WACC-1:0];
                    end else begin
                        case (mode_q)
                            MODE_WRAP: begin
                                freq_nx = f_start_q;
                                wrap_nx = 1'b1;
                            end
                            MODE_BOUNCE: begin
                                freq_nx  = f_stop_q;
                                state_nx = ST_DOWN;
                                wrap_nx  = 1'b1;
                            end
                            MODE_SINGLE: begin
                                freq_nx  = f_stop_q;
                                state_nx = ST_LAST;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_DOWN: begin
                if (!bus.enable) begin
                    state_nx = ST_IDLE;
                end else if (strobe) begin
                    if (!dn_diff[WACC] && dn_diff[WACC-1:0] >= f_start_q) begin
                        freq_nx = dn_diff[WACC-1:0];
                    end else begin
                        freq_nx  = f_start_q;
                        state_nx = ST_UP;
                        wrap_nx  = 1'b1;
                    end
                end
            end
            ST_LAST: begin
                if (!bus.enable)  state_nx = ST_IDLE;
                else if (strobe)  state_nx = ST_DONE;
            end
            ST_DONE: if (!bus.enable) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_TONE;
            div_q     <= '0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            rate_q    <= '0;
            phase     <= '0;
            freq      <= '0;
            wrap_pend <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                mode_q    <= mode_t'(bus.mode);
                div_q     <= bus.div;
                f_start_q <= bus.f_start;
                f_stop_q  <= bus.f_stop;
                rate_q    <= bus.rate;
                phase     <= '0;
                freq      <= bus.f_start;
                wrap_pend <= 1'b0;
            end else if (strobe) begin
                phase     <= phase + freq;
                freq      <= freq_nx;
                wrap_pend <= wrap_nx;
            end
        end
    end

    // Sample register: carries the pre-update phase/freq; zero between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            phase_q <= '0;
            freq_q  <= '0;
        end else begin
            valid_q <= strobe;
            wrap_q  <= strobe && wrap_pend;
            phase_q <= strobe ? phase[WACC-1 -: WPHASE] : '0;
            freq_q  <= strobe ? freq : '0;
        end
    end

    assign bus.phase_valid = valid_q;
    assign bus.sweep_wrap  = wrap_q;
    assign bus.phase_out   = phase_q;
    assign bus.freq_out    = freq_q;
    assign bus.busy        = state inside {ST_UP, ST_DOWN, ST_LAST};
    assign bus.done        = (state == ST_DONE);
endmodule
